coin_return_dispenser: RTL and testbench
========================================

Name: coin_return_dispenser

Overview:
- Sequential payout end of the vending-machine coin path: takes a refund amount and pays it out one coin at a time to the coin hopper over a valid/ready handshake.
- Coin choice is greedy: largest denomination that fits the remaining balance and is in stock.
- Holds a per-denomination coin inventory (reset load, refill, decrement on payout) and reports the unpaid remainder and a stock shortfall flag when done.

Parameters:
- kNumCoins, 3, number of denominations; bit 0 = 100, bit 1 = 500, bit 2 = 1000.
- BAL_W, 31, width of the amount and balance.
- CNT_W, 8, width of each inventory counter.
- INIT_CNT, 20, inventory count loaded into every denomination on reset.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- i_start, input, 1: request a payout; sampled only in IDLE.
- i_return_amount, input, BAL_W: refund amount, latched on the i_start edge.
- i_hopper_ready, input, 1: hopper accepts the presented coin on this edge.
- i_refill, input, kNumCoins: one-hot denomination select for a refill.
- i_refill_cnt, input, CNT_W: number of coins added by the refill.
- o_return_coin, output, kNumCoins: one-hot coin presented (valid); 0 means none.
- o_busy, output, 1: high in DISPENSE.
- o_done, output, 1: one-cycle pulse in DONE.
- o_remainder, output, BAL_W: unpaid balance; valid from DONE until the next start.
- o_shortfall, output, 1: set in DONE when the remainder is >= 100.
- o_empty, output, kNumCoins: bit i is high when inventory[i] == 0.

Behaviour:
- Reset (asynchronous, any state, including mid-payout):
  - State goes to IDLE; o_return_coin, o_busy, o_done, o_remainder, o_shortfall and the balance go to 0.
  - Every inventory counter loads INIT_CNT, so o_empty = 0.
- choice(bal, inv):
  - 1000 if bal >= 1000 and inv[2] > 0.
  - Otherwise 500 if bal >= 500 and inv[1] > 0.
  - Otherwise 100 if bal >= 100 and inv[0] > 0.
  - Otherwise none.
- States are IDLE, DISPENSE and DONE, all registered.
- IDLE:
  - On i_start: balance <= i_return_amount and o_return_coin <= choice(i_return_amount, inv).
  - If that choice is none, go to DONE; otherwise go to DISPENSE.
  - A refill (i_refill != 0) is applied only in IDLE: inv[sel] <= min(inv[sel] + i_refill_cnt, 2^CNT_W - 1), saturating.
  - Refill and i_start may coincide; the refill takes effect after that edge and is not used for the first choice.
  - i_refill with more than one bit set is ignored.
- DISPENSE:
  - o_return_coin is held stable until an edge where o_return_coin != 0 and i_hopper_ready = 1 (transfer).
  - On a transfer edge: balance -= value, inv[coin] -= 1, and o_return_coin <= choice(new balance, new inv), all computed in the same edge.
  - Back-to-back coins are therefore possible, one per cycle.
  - If the new choice is none, o_return_coin <= 0 and the state goes to DONE.
  - i_start and i_refill are ignored in DISPENSE.
- DONE (exactly one cycle):
  - o_done = 1 and o_busy = 0.
  - o_remainder = balance; o_shortfall = (balance >= 100).
  - The next state is IDLE.
- Arithmetic and boundaries:
  - The balance never goes negative; a coin is only chosen when value <= balance.
  - Any balance amount not a multiple of 100 stays in o_remainder with o_shortfall = 0 if it is < 100.
  - Amount 0: IDLE → DONE → IDLE, no coins, o_remainder = 0.
  - An inventory counter never goes below 0, guaranteed by choice requiring inv > 0.
  - o_empty is combinational from the counters.
- Latency: the first coin is presented the cycle after i_start. With i_hopper_ready held high, N coins take N cycles, followed by one DONE cycle.

Test Plan:
- Full stock, i_start with 1600, ready held high → coins 100b, 010b, 001b on three consecutive cycles; then o_done, o_remainder = 0, o_shortfall = 0.
- Same start with ready low for 3 cycles, then high → 100b held unchanged for those 3 cycles; sequence resumes with no coin lost or duplicated; inv[2] = 19 at end.
- inv[2] = 0 (reset INIT_CNT = 0 for 1000 via refill test variant), amount 2000 → four 010b coins; inv[1] decreases by 4.
- Amount 250 → 001b, 001b; o_remainder = 50, o_shortfall = 0. Amount 300 with inv[0] = 1, inv[1] = 0, inv[2] = 0 → one 001b coin; o_remainder = 200, o_shortfall = 1, o_empty[0] = 1.
- Assert reset mid-DISPENSE after 1 coin → o_return_coin = 0 and o_busy = 0 immediately (async); all inventories = INIT_CNT; i_start pulsed during DISPENSE → ignored, balance unchanged.
- Refill in IDLE: inv[0] = 250 plus i_refill_cnt = 10 → saturates at 255. The same refill issued during DISPENSE leaves the inventory unchanged.

Source files
------------

// File: rtl/coin_return_dispenser.sv
// Coin return dispenser: pays a refund out one coin per handshake, choosing the largest
// in-stock denomination that fits, while keeping a saturating per-denomination inventory.
module coin_return_dispenser #(
    parameter int kNumCoins = 3,
    parameter int BAL_W     = 31,
    parameter int CNT_W     = 8,
    parameter int INIT_CNT  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [BAL_W-1:0]     i_return_amount,
    input  logic                 i_hopper_ready,
    input  logic [kNumCoins-1:0] i_refill,
    input  logic [CNT_W-1:0]     i_refill_cnt,
    output logic [kNumCoins-1:0] o_return_coin,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [BAL_W-1:0]     o_remainder,
    output logic                 o_shortfall,
    output logic [kNumCoins-1:0] o_empty
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [BAL_W-1:0] MIN_COIN = BAL_W'(100);

    state_t                 state;
    state_t                 state_next;
    logic [BAL_W-1:0]       balance;
    logic [BAL_W-1:0]       balance_next;
    logic [BAL_W-1:0]       bal_after;
    logic [kNumCoins-1:0]   coin_next;
    logic [BAL_W-1:0]       remainder_next;
    logic                   shortfall_next;
    logic                   transfer;
    logic [CNT_W-1:0]       inv        [kNumCoins];
    logic [CNT_W-1:0]       inv_next   [kNumCoins];
    logic [CNT_W-1:0]       inv_after  [kNumCoins];
    logic [CNT_W-1:0]       refill_sat [kNumCoins];
    logic [CNT_W:0]         refill_sum [kNumCoins];

    function automatic logic [BAL_W-1:0] coin_value(input int idx);
        case (idx)
            0:       coin_value = BAL_W'(100);
            1:       coin_value = BAL_W'(500);
            default: coin_value = BAL_W'(1000);
        endcase
    endfunction

    function automatic logic [BAL_W-1:0] coin_amount(input logic [kNumCoins-1:0] coin);
        coin_amount = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (coin[i]) begin
                coin_amount = coin_amount + coin_value(i);
            end
        end
    endfunction

    // Ascending scan so the largest qualifying denomination overwrites smaller ones.
    function automatic logic [kNumCoins-1:0] choose(input logic [BAL_W-1:0] bal,
                                                    input logic [CNT_W-1:0] cnt [kNumCoins]);
        choose = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (bal >= coin_value(i) && cnt[i] != '0) begin
                choose    = '0;
                choose[i] = 1'b1;
            end
        end
    endfunction

    assign transfer = (o_return_coin != '0) && i_hopper_ready;
    assign o_busy   = (state == DISPENSE);
    assign o_done   = (state == DONE);

    always_comb begin
        for (int i = 0; i < kNumCoins; i++) begin
            o_empty[i] = (inv[i] == '0);
        end
    end

    always_comb begin
        bal_after = balance - coin_amount(o_return_coin);
        for (int i = 0; i < kNumCoins; i++) begin
            refill_sum[i] = {1'b0, inv[i]} + {1'b0, i_refill_cnt};
            refill_sat[i] = refill_sum[i][CNT_W] ? {CNT_W{1'b1}} : refill_sum[i][CNT_W-1:0];
            inv_after[i]  = inv[i] - CNT_W'(o_return_coin[i]);
        end
    end

    always_comb begin
        state_next     = state;
        balance_next   = balance;
        coin_next      = o_return_coin;
        remainder_next = o_remainder;
        shortfall_next = o_shortfall;
        for (int i = 0; i < kNumCoins; i++) begin
            inv_next[i] = inv[i];
        end

        unique case (state)
            IDLE: begin
                // The first choice uses pre-refill stock; a coincident refill lands on this edge.
                if ($onehot(i_refill)) begin
                    for (int i = 0; i < kNumCoins; i++) begin
                        if (i_refill[i]) begin
                            inv_next[i] = refill_sat[i];
                        end
                    end
                end
                if (i_start) begin
                    balance_next = i_return_amount;
                    coin_next    = choose(i_return_amount, inv);
                    if (coin_next == '0) begin
                        state_next     = DONE;
                        remainder_next = i_return_amount;
                        shortfall_next = (i_return_amount >= MIN_COIN);
                    end else begin
                        state_next = DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                if (transfer) begin
                    balance_next = bal_after;
                    coin_next    = choose(bal_after, inv_after);
                    for (int i = 0; i < kNumCoins; i++) begin
                        inv_next[i] = inv_after[i];
                    end
                    if (coin_next == '0) begin
                        state_next     = DONE;
                        remainder_next = bal_after;
                        shortfall_next = (bal_after >= MIN_COIN);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            balance       <= '0;
            o_return_coin <= '0;
            o_remainder   <= '0;
            o_shortfall   <= 1'b0;
            for (int i = 0; i < kNumCoins; i++) begin
                inv[i] <= CNT_W'(INIT_CNT);
            end
        end else begin
            balance       <= balance_next;
            o_return_coin <= coin_next;
            o_remainder   <= remainder_next;
            o_shortfall   <= shortfall_next;
            for (int i = 0; i < kNumCoins; i++) begin
                inv[i] <= inv_next[i];
            end
        end
    end

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed scenarios plus randomized payouts checked
// cycle by cycle against a greedy change-making model with its own inventory.
module tb_coin_return_dispenser;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [30:0] i_return_amount;
    logic        i_hopper_ready;
    logic [2:0]  i_refill;
    logic [7:0]  i_refill_cnt;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_remainder;
    logic        o_shortfall;
    logic [2:0]  o_empty;

    int compared   = 0;
    int mismatched = 0;

    localparam int unsigned kValue [3] = '{100, 500, 1000};
    int unsigned m_inv [3];
    int unsigned m_bal;
    logic [2:0]  m_coin;

    always #5 clk = ~clk;

    coin_return_dispenser dut (
        .clk             (clk),
        .reset           (reset),
        .i_start         (i_start),
        .i_return_amount (i_return_amount),
        .i_hopper_ready  (i_hopper_ready),
        .i_refill        (i_refill),
        .i_refill_cnt    (i_refill_cnt),
        .o_return_coin   (o_return_coin),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_remainder     (o_remainder),
        .o_shortfall     (o_shortfall),
        .o_empty         (o_empty)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] greedy(input int unsigned bal);
        for (int i = 2; i >= 0; i--) begin
            if (bal >= kValue[i] && m_inv[i] > 0) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    function automatic logic [2:0] expEmpty();
        return {m_inv[2] == 0, m_inv[1] == 0, m_inv[0] == 0};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 3; i++) m_inv[i] = 20;
        m_bal  = 0;
        m_coin = 3'b000;
    endtask

    task automatic modelRefill(input logic [2:0] sel, input logic [7:0] cnt);
        if ($onehot(sel)) begin
            for (int i = 0; i < 3; i++) begin
                if (sel[i]) m_inv[i] = (m_inv[i] + cnt > 255) ? 255 : m_inv[i] + cnt;
            end
        end
    endtask

    task automatic checkInventory(input string tag);
        checkOutput({tag, "_inv0"}, dut.inv[0], m_inv[0]);
        checkOutput({tag, "_inv1"}, dut.inv[1], m_inv[1]);
        checkOutput({tag, "_inv2"}, dut.inv[2], m_inv[2]);
        checkOutput({tag, "_empty"}, o_empty, expEmpty());
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic applyStimulus(input int unsigned amount, input int ready_pct, input int stall,
                                 input bit noise, input logic [2:0] rsel, input logic [7:0] rcnt);
        bit done_seen;
        bit ready;
        i_start         = 1'b1;
        i_return_amount = 31'(amount);
        i_refill        = rsel;
        i_refill_cnt    = rcnt;
        m_bal  = amount;
        m_coin = greedy(amount);
        modelRefill(rsel, rcnt);
        @(negedge clk);
        i_start   = 1'b0;
        i_refill  = 3'b000;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            if (m_coin == 3'b000) begin
                checkOutput("done_pulse", o_done, 1);
                checkOutput("done_busy", o_busy, 0);
                checkOutput("done_coin", o_return_coin, 0);
                checkOutput("remainder", o_remainder, m_bal);
                checkOutput("shortfall", o_shortfall, m_bal >= 100);
                checkOutput("done_empty", o_empty, expEmpty());
                i_hopper_ready = 1'b0;
                i_start        = 1'b0;
                i_refill       = 3'b000;
                done_seen      = 1'b1;
            end else begin
                checkOutput("coin", o_return_coin, m_coin);
                checkOutput("busy", o_busy, 1);
                checkOutput("not_done", o_done, 0);
                ready = (cyc >= stall) && ($urandom_range(99) < ready_pct);
                i_hopper_ready = ready;
                if (noise) begin
                    i_start         = 1'($urandom_range(1));
                    i_return_amount = 31'($urandom);
                    i_refill        = 3'($urandom);
                    i_refill_cnt    = 8'($urandom);
                end
                if (ready) begin
                    for (int i = 0; i < 3; i++) begin
                        if (m_coin[i]) begin
                            m_bal    = m_bal - kValue[i];
                            m_inv[i] = m_inv[i] - 1;
                        end
                    end
                    m_coin = greedy(m_bal);
                end
            end
            @(negedge clk);
        end
        checkOutput("done_reached", done_seen, 1);
        checkOutput("idle_busy", o_busy, 0);
        checkOutput("idle_done", o_done, 0);
    endtask

    initial begin
        reset           = 1'b1;
        i_start         = 1'b0;
        i_return_amount = '0;
        i_hopper_ready  = 1'b0;
        i_refill        = 3'b000;
        i_refill_cnt    = 8'd0;
        modelReset();
        @(negedge clk);
        checkOutput("rst_coin", o_return_coin, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_remainder", o_remainder, 0);
        checkOutput("rst_shortfall", o_shortfall, 0);
        checkOutput("rst_empty", o_empty, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] 1600 with ready held high");
        applyStimulus(1600, 100, 0, 1'b0, 3'b000, 8'd0);
        $display("[TB] 1600 with 3 stall cycles and ignored start/refill noise");
        applyStimulus(1600, 100, 3, 1'b1, 3'b000, 8'd0);
        checkInventory("after_1600");

        $display("[TB] drain 1000s, then 2000 pays four 500s");
        applyStimulus(1000 * m_inv[2], 100, 0, 1'b0, 3'b000, 8'd0);
        checkOutput("empty_1000", o_empty[2], 1);
        applyStimulus(2000, 100, 0, 1'b0, 3'b000, 8'd0);
        checkInventory("after_2000");

        $display("[TB] 250 leaves 50");
        applyStimulus(250, 100, 0, 1'b0, 3'b000, 8'd0);

        $display("[TB] exhaust stock down to one 100, then 300");
        applyStimulus(500 * m_inv[1], 100, 0, 1'b0, 3'b000, 8'd0);
        applyStimulus(100 * (m_inv[0] - 1), 100, 0, 1'b0, 3'b000, 8'd0);
        applyStimulus(300, 100, 0, 1'b0, 3'b000, 8'd0);
        checkOutput("all_empty", o_empty, 3'b111);
        applyStimulus(0, 100, 0, 1'b0, 3'b000, 8'd0);

        $display("[TB] reset mid-payout");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        i_start         = 1'b1;
        i_return_amount = 31'd1600;
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("mid_coin0", o_return_coin, 3'b100);
        i_hopper_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_coin1", o_return_coin, 3'b010);
        reset = 1'b1;
        #1;
        checkOutput("async_coin", o_return_coin, 0);
        checkOutput("async_busy", o_busy, 0);
        checkOutput("async_remainder", o_remainder, 0);
        checkInventory("async");
        @(negedge clk);
        reset          = 1'b0;
        i_hopper_ready = 1'b0;
        @(negedge clk);

        $display("[TB] saturating refill");
        i_refill     = 3'b001;
        i_refill_cnt = 8'(250 - m_inv[0]);
        modelRefill(i_refill, i_refill_cnt);
        @(negedge clk);
        checkInventory("refill250");
        i_refill_cnt = 8'd10;
        modelRefill(i_refill, i_refill_cnt);
        @(negedge clk);
        checkInventory("refill_sat");
        i_refill     = 3'b011;
        i_refill_cnt = 8'd5;
        modelRefill(i_refill, i_refill_cnt);
        @(negedge clk);
        i_refill = 3'b000;
        checkInventory("refill_multi");
        applyStimulus(1600, 50, 2, 1'b1, 3'b000, 8'd0);
        checkInventory("refill_in_dispense");

        $display("[TB] randomized payouts");
        for (int n = 0; n < 20; n++) begin
            applyStimulus($urandom_range(4000), $urandom_range(30, 100), $urandom_range(2), 1'b1,
                          3'($urandom), 8'($urandom_range(40)));
            checkInventory("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
